// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared register-file definitions used by the dump controller and other
// register-file clients: index width, data width and dump state encoding.
package regfile_dump_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl_hs_out_reg.sv
// Holding register for the streamed (index, value) pair; loaded once per
// register and kept stable until the FSM reloads it for the next one.
module hs_out_reg
    import regfile_dump_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [REG_ADDR_W-1:0] load_idx,
    input  logic [XLEN-1:0]       load_data,
    output logic [REG_ADDR_W-1:0] idx,
    output logic [XLEN-1:0]       data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            data <= '0;
        end else if (load) begin
            idx  <= load_idx;
            data <= load_data;
        end
    end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Debug initiator that walks registers FIRST_REG..LAST_REG through a shared
// read port and streams (index, value) pairs while stalling core writes.
module regfile_dump_ctrl
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  stall_req,
    output logic [REG_ADDR_W-1:0] rf_addr,
    input  logic [XLEN-1:0]       rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_idx,
    output logic [XLEN-1:0]       out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int MAX_REG = (1 << REG_ADDR_W) - 1;
    localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

    generate
        if (FIRST_REG < 0 || LAST_REG > MAX_REG || LAST_REG < FIRST_REG) begin : g_bad_range
            $error("regfile_dump_ctrl: register range %0d..%0d is invalid", FIRST_REG, LAST_REG);
        end
    endgenerate

    dump_state_e           state, state_nxt;
    logic [REG_ADDR_W-1:0] addr, addr_nxt;
    logic                  load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr  <= FIRST_A;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    // abort is tested ahead of every other transition, so a pair being
    // handshaken in the same cycle is dropped rather than delivered
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        load      = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        stall_req = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && !abort) begin
                    state_nxt = READ;
                    addr_nxt  = FIRST_A;
                end
            end
            READ: begin
                stall_req = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    load      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                stall_req = 1'b1;
                out_valid = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    if (addr == LAST_A) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt  = addr + 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rf_addr = addr;

    hs_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_idx  (addr),
        .load_data (rf_data),
        .idx       (out_idx),
        .data      (out_data)
    );

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench: a register-file snapshot taken at each start predicts the
// stream; a negedge monitor pops and compares every accepted pair.
module tb_regfile_dump_ctrl;
    import regfile_dump_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, out_ready;
    logic        stall_req, out_valid, busy, done;
    logic [4:0]  rf_addr, out_idx;
    logic [31:0] rf_data, out_data;

    logic        start2;
    logic        abort2 = 1'b0;
    logic        out_ready2 = 1'b1;
    logic        stall_req2, out_valid2, busy2, done2;
    logic [4:0]  rf_addr2, out_idx2;
    logic [31:0] rf_data2, out_data2;

    logic [31:0] regs [32];
    assign rf_data  = regs[rf_addr];
    assign rf_data2 = regs[rf_addr2];

    regfile_dump_ctrl #(.FIRST_REG(0), .LAST_REG(31)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stall_req(stall_req),
        .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .busy(busy), .done(done)
    );

    regfile_dump_ctrl #(.FIRST_REG(10), .LAST_REG(10)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .stall_req(stall_req2),
        .rf_addr(rf_addr2), .rf_data(rf_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_idx(out_idx2), .out_data(out_data2), .busy(busy2), .done(done2)
    );

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } pair_t;

    pair_t exp_q[$];
    pair_t exp_q2[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_acc2  = 0;
    int n_done  = 0;
    int cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pair is delivered when valid&&ready at the edge and abort is low
    always @(negedge clk) begin
        pair_t p;
        if (!rst && out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pair: got idx %0d data 0x%0h, expected no pair", out_idx, out_data);
            end else begin
                p = exp_q.pop_front();
                check("pair_idx", {27'd0, out_idx}, {27'd0, p.idx});
                check("pair_data", out_data, p.data);
            end
        end
        if (!rst && out_valid2 && out_ready2 && !abort2) begin
            if (exp_q2.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pair2: got idx %0d data 0x%0h, expected no pair", out_idx2, out_data2);
            end else begin
                p = exp_q2.pop_front();
                check("pair2_idx", {27'd0, out_idx2}, {27'd0, p.idx});
                check("pair2_data", out_data2, p.data);
                n_acc2++;
            end
        end
        if (!rst && done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        pair_t p;
        for (int i = 0; i < 32; i++) begin
            p.idx  = 5'(i);
            p.data = regs[i];
            exp_q.push_back(p);
        end
    endtask

    task automatic pulse_start();
        push_dump();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic run_to_done(input int limit, input bit rand_rdy);
        while (!done && cyc < limit) begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
        end
        check("done_within_budget", {31'd0, done}, 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic rf_write(input int a, input logic [31:0] d);
        if (!stall_req && !stall_req2 && a != 0) regs[a] = d;
    endtask

    task automatic wait_idx(input logic [4:0] idx);
        while (!(out_valid && out_idx == idx) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("reached_idx", {31'd0, out_valid && out_idx == idx}, 32'd1);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; start2 = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_out_idx", {27'd0, out_idx}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
        check("rst_rf_addr2", {27'd0, rf_addr2}, 32'd10);
        rst = 1'b0;
        tick();

        // Full dump with ready tied high: latency and done timing
        pulse_start();
        check("read_no_valid", {31'd0, out_valid}, 32'd0);
        check("read_busy", {31'd0, busy}, 32'd1);
        tick(); cyc++;
        check("first_valid_latency", {31'd0, out_valid}, 32'd1);
        run_to_done(200, 1'b0);
        check("full_dump_cycles", 32'(cyc), 32'd65);
        check("done_stall_low", {31'd0, stall_req}, 32'd0);
        tick();
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("done_one_pulse", 32'(n_done), 32'd1);
        check("full_dump_drained", 32'(exp_q.size()), 32'd0);

        // Single-register instance; start during its dump is ignored
        exp_q2.push_back('{idx: 5'd10, data: regs[10]});
        start2 = 1'b1;
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("solo_valid", {31'd0, out_valid2}, 32'd1);
        check("solo_idx", {27'd0, out_idx2}, 32'd10);
        tick();
        check("solo_done", {31'd0, done2}, 32'd1);
        repeat (6) tick();
        check("solo_idle", {31'd0, busy2}, 32'd0);
        check("solo_one_pair", 32'(n_acc2), 32'd1);

        // Backpressure on idx 7
        pulse_start();
        wait_idx(5'd7);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_idx", {27'd0, out_idx}, 32'd7);
            check("bp_data", out_data, 32'h1000_0007);
            check("bp_rf_addr", {27'd0, rf_addr}, 32'd7);
        end
        out_ready = 1'b1;
        tick();
        check("bp_gap", {31'd0, out_valid}, 32'd0);
        tick();
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_idx", {27'd0, out_idx}, 32'd8);
        run_to_done(300, 1'b0);
        tick();
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Snapshot: core write to x5 blocked while stalling
        pulse_start();
        repeat (3) tick();
        check("snap_stall", {31'd0, stall_req}, 32'd1);
        rf_write(5, 32'hDEAD_BEEF);
        check("snap_blocked", regs[5], 32'h1000_0005);
        cyc = 4;
        run_to_done(400, 1'b1);
        tick();
        rf_write(5, 32'hDEAD_BEEF);
        check("snap_write_after", regs[5], 32'hDEAD_BEEF);
        pulse_start();
        run_to_done(400, 1'b1);
        tick();
        check("snap_drained", 32'(exp_q.size()), 32'd0);

        // Abort coinciding with the idx 12 handshake
        pulse_start();
        wait_idx(5'd12);
        d0 = n_done;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_stall", {31'd0, stall_req}, 32'd0);
        check("abort_remaining", 32'(exp_q.size()), 32'd20);
        exp_q.delete();
        repeat (4) tick();
        check("abort_no_done", 32'(n_done), 32'(d0));
        pulse_start();
        run_to_done(200, 1'b0);
        tick();
        check("restart_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of SEND
        pulse_start();
        wait_idx(5'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_stall", {31'd0, stall_req}, 32'd0);
        check("arst_out_data", out_data, 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();

        // Randomised register contents and random backpressure
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i < 32; i++) regs[i] = $urandom;
            pulse_start();
            run_to_done(500, 1'b1);
            tick();
            check("rand_drained", 32'(exp_q.size()), 32'd0);
            check("rand_idle", {31'd0, busy}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
